// File: rtl/mips_mem_responder.sv
// Memory-side responder for the 8-bit multicycle MIPS core: byte RAM, one
// memory-mapped output register, and a byte-stream loader that holds the CPU in reset.
module mips_mem_responder #(
  parameter int                WIDTH   = 8,
  parameter logic [WIDTH-1:0]  IO_ADDR = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] memdata,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             cpu_rst,
  output logic [WIDTH-1:0] io_out,
  output logic             io_strobe
);

  localparam int DEPTH = 1 << WIDTH;

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] memdata_q;
  logic [WIDTH-1:0] io_out_q;
  logic             io_strobe_q;
  logic             ld_ready_q;
  logic             cpu_rst_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             io_hit;
  logic             last_beat;
  logic             ram_we;
  logic [WIDTH-1:0] ram_adr;
  logic [WIDTH-1:0] ram_wdata;

  assign io_hit    = (adr == IO_ADDR);
  assign last_beat = ld_last || (ptr_q == {WIDTH{1'b1}});

  // One RAM write port shared by the loader (LOAD) and the CPU (RUN); held off during reset.
  always_comb begin
    ram_we    = 1'b0;
    ram_adr   = adr;
    ram_wdata = writedata;
    if (!rst) begin
      if (state_q == LOAD) begin
        ram_we    = ld_valid;
        ram_adr   = ptr_q;
        ram_wdata = ld_data;
      end else begin
        ram_we = memwrite && !io_hit;
      end
    end
  end

  // RAM contents are intentionally not reset so they survive a CPU restart.
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_adr] <= ram_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      ptr_q       <= '0;
      memdata_q   <= '0;
      io_out_q    <= '0;
      io_strobe_q <= 1'b0;
      ld_ready_q  <= 1'b1;
      cpu_rst_q   <= 1'b1;
    end else begin
      io_strobe_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (ld_valid) begin
            ptr_q <= ptr_q + 1'b1;
            if (last_beat) begin
              state_q    <= RUN;
              ld_ready_q <= 1'b0;
              cpu_rst_q  <= 1'b0;
            end
          end
        end
        RUN: begin
          // A simultaneous read and write performs only the write.
          if (memwrite) begin
            if (io_hit) begin
              io_out_q    <= writedata;
              io_strobe_q <= 1'b1;
            end
          end else if (memread) begin
            memdata_q <= io_hit ? io_out_q : mem_q[adr];
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign memdata   = memdata_q;
  assign io_out    = io_out_q;
  assign io_strobe = io_strobe_q;
  assign ld_ready  = ld_ready_q;
  assign cpu_rst   = cpu_rst_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed self-checking bench for mips_mem_responder: loader sessions, CPU
// reads/writes, the IO register and reset behaviour.
module tb_mips_mem_responder;

  logic       clk = 1'b0;
  logic       rst, memread, memwrite, ld_valid, ld_last;
  logic [7:0] adr, writedata, ld_data;
  logic [7:0] memdata, io_out;
  logic       ld_ready, cpu_rst, io_strobe;

  int checks = 0;
  int errors = 0;

  mips_mem_responder #(.WIDTH(8), .IO_ADDR(8'hFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .memread   (memread),
    .memwrite  (memwrite),
    .adr       (adr),
    .writedata (writedata),
    .memdata   (memdata),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .cpu_rst   (cpu_rst),
    .io_out    (io_out),
    .io_strobe (io_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a);
    memread = 1'b1; adr = a;
    tick();
    memread = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    memwrite = 1'b1; adr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] img(input int i);
    return 8'(i) ^ 8'h5A;
  endfunction

  logic [7:0] first4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    rst = 1'b0; memread = 1'b0; memwrite = 1'b0; adr = '0; writedata = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    #1;
    do_reset();
    chk("rst_memdata", memdata, 8'h00);
    chk("rst_io_out", io_out, 8'h00);
    chk("rst_strobe", io_strobe, 1'b0);
    chk("rst_cpu_rst", cpu_rst, 1'b1);
    chk("rst_ld_ready", ld_ready, 1'b1);

    // Full 256-byte gapped image, no ld_last.
    for (int i = 0; i < 256; i++) begin
      if (i % 3 == 2) begin
        ld_valid = 1'b0;
        tick();
      end
      ld_valid = 1'b1; ld_data = img(i);
      tick();
      if (i == 254) begin
        chk("full_cpu_rst_b254", cpu_rst, 1'b1);
        chk("full_ld_ready_b254", ld_ready, 1'b1);
      end
    end
    ld_valid = 1'b0;
    chk("full_cpu_rst_b255", cpu_rst, 1'b0);
    chk("full_ld_ready_b255", ld_ready, 1'b0);
    rd(8'h00); chk("full_rd_00", memdata, 8'h5A);
    rd(8'h80); chk("full_rd_80", memdata, 8'hDA);
    rd(8'hFE); chk("full_rd_FE", memdata, 8'hA4);
    chk("full_ram_FF", dut.mem_q[8'hFF], 8'hA5);

    // New session: CPU traffic during LOAD is ignored.
    do_reset();
    wr(8'h20, 8'h99);
    rd(8'h21);
    chk("load_rd_ignored", memdata, 8'h00);
    wr(8'hFF, 8'h33);
    chk("load_io_ignored", io_out, 8'h00);
    chk("load_strobe_ignored", io_strobe, 1'b0);

    // Four-byte image with ld_last.
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = first4[i]; ld_last = (i == 3);
      tick();
      if (i == 2) chk("ld4_cpu_rst_b2", cpu_rst, 1'b1);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("ld4_cpu_rst_b3", cpu_rst, 1'b0);
    chk("ld4_ld_ready_b3", ld_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rd(8'(i));
      chk($sformatf("ld4_rd_%0d", i), memdata, first4[i]);
    end
    rd(8'h20); chk("load_wr_ignored", memdata, 8'h7A);

    // Read, then hold.
    rd(8'h02); chk("run_rd_02", memdata, 8'h33);
    tick();    chk("run_hold_02", memdata, 8'h33);

    // Read-after-write.
    wr(8'h10, 8'hA5);
    rd(8'h10); chk("raw_10", memdata, 8'hA5);

    // IO register and strobe.
    wr(8'hFF, 8'h5C);
    chk("io_out_5C", io_out, 8'h5C);
    chk("io_strobe_1", io_strobe, 1'b1);
    tick();
    chk("io_strobe_0", io_strobe, 1'b0);
    rd(8'hFF); chk("io_rd_5C", memdata, 8'h5C);
    chk("io_ram_FF_kept", dut.mem_q[8'hFF], 8'hA5);
    wr(8'hFF, 8'h77);
    chk("io_strobe_2nd", io_strobe, 1'b1);
    chk("io_out_77", io_out, 8'h77);
    rd(8'hFF);
    chk("io_strobe_2nd_end", io_strobe, 1'b0);
    chk("io_raw_77", memdata, 8'h77);

    // Read and write together: write wins, memdata holds.
    memread = 1'b1; memwrite = 1'b1; adr = 8'h11; writedata = 8'hC3;
    tick();
    memread = 1'b0; memwrite = 1'b0;
    chk("rw_hold", memdata, 8'h77);
    rd(8'h11); chk("rw_wrote", memdata, 8'hC3);

    // Reset mid-RUN, then one-byte reload.
    wr(8'hFF, 8'h5C);
    rd(8'h10);
    do_reset();
    chk("rr_io_out", io_out, 8'h00);
    chk("rr_memdata", memdata, 8'h00);
    chk("rr_cpu_rst", cpu_rst, 1'b1);
    chk("rr_ld_ready", ld_ready, 1'b1);
    ld_valid = 1'b1; ld_data = 8'hEE; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("rr_cpu_rst_run", cpu_rst, 1'b0);
    rd(8'h10); chk("rr_rd_10", memdata, 8'hA5);
    rd(8'h00); chk("rr_rd_00", memdata, 8'hEE);
    rd(8'h01); chk("rr_rd_01", memdata, 8'h22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
